// File: rtl/bcd_segment_scanner_pkg.sv
// Shared types and segment patterns for the
// multiplexed 7-segment scanner.
package seg_pkg;

  typedef logic [3:0] digit_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // active-low {g,f,e,d,c,b,a} for decimal 0..9
  localparam logic [6:0] DIGIT_SEG [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

endpackage

// File: rtl/bcd_segment_scanner_if.sv
// Display-side bundle: load request, digit data,
// and the multiplexed pin/status outputs.
interface bcd_segment_scanner_if #(
  parameter int NUM_DIGITS = 4
);

  logic                      load;
  logic [4*NUM_DIGITS-1:0]   digits_in;
  logic [NUM_DIGITS-1:0]     blank_in;
  logic [6:0]                seg;
  logic [NUM_DIGITS-1:0]     an;
  logic                      applied;
  logic                      frame_done;

  modport master (
    output load, digits_in, blank_in,
    input  seg, an, applied, frame_done
  );

  modport slave (
    input  load, digits_in, blank_in,
    output seg, an, applied, frame_done
  );

endinterface

// File: rtl/bcd_segment_scanner_decode.sv
// Binary digit code to active-low 7-segment pattern.
// Codes above 9 show a dash as an error marker.
module seg7_decode
  import seg_pkg::*;
(
  input  digit_t     code,
  output logic [6:0] seg
);

  // pure lookup, dash for anything non-decimal
  always_comb begin
    seg = SEG_DASH;
    case (code)
      4'd0: seg = DIGIT_SEG[0];
      4'd1: seg = DIGIT_SEG[1];
      4'd2: seg = DIGIT_SEG[2];
      4'd3: seg = DIGIT_SEG[3];
      4'd4: seg = DIGIT_SEG[4];
      4'd5: seg = DIGIT_SEG[5];
      4'd6: seg = DIGIT_SEG[6];
      4'd7: seg = DIGIT_SEG[7];
      4'd8: seg = DIGIT_SEG[8];
      4'd9: seg = DIGIT_SEG[9];
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_segment_scanner.sv
// Time-multiplexed common-anode display driver with
// a shadow copy that only changes on frame boundaries.
module bcd_segment_scanner
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000
)(
  input  logic CLK,
  input  logic rst_n,
  bcd_segment_scanner_if.slave bus
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int DW = 4 * NUM_DIGITS;

  localparam logic [PW-1:0] P_LAST =
    PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] I_LAST =
    IW'(NUM_DIGITS - 1);

  logic [PW-1:0]         presc;
  logic [IW-1:0]         idx;
  logic                  tc;
  logic                  fb;

  logic                  pending;
  logic [DW-1:0]         pend_dig;
  logic [NUM_DIGITS-1:0] pend_blank;
  logic [DW-1:0]         shad_dig;
  logic [NUM_DIGITS-1:0] shad_blank;

  digit_t                cur_code;
  logic                  cur_blank;
  logic [6:0]            cur_seg;

  logic [6:0]            seg_q;
  logic [NUM_DIGITS-1:0] an_q;
  logic                  applied_q;
  logic                  fd_q;

  assign tc = (presc == P_LAST);
  assign fb = tc && (idx == I_LAST);

  assign cur_code  = shad_dig[{idx, 2'b00} +: 4];
  assign cur_blank = shad_blank[idx];

  seg7_decode u_dec (
    .code (cur_code),
    .seg  (cur_seg)
  );

  // refresh prescaler and scanned digit index
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      presc <= '0;
      idx   <= '0;
    end else if (tc) begin
      presc <= '0;
      idx   <= (idx == I_LAST) ? '0 : idx + 1'b1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // pending buffer: last load before a boundary wins
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      pending    <= 1'b0;
      pend_dig   <= '0;
      pend_blank <= '1;
    end else if (fb) begin
      pending <= 1'b0;
    end else if (bus.load) begin
      pending    <= 1'b1;
      pend_dig   <= bus.digits_in;
      pend_blank <= bus.blank_in;
    end
  end

  // shadow copy changes only at the frame boundary
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      shad_dig   <= '0;
      shad_blank <= '1;
      applied_q  <= 1'b0;
      fd_q       <= 1'b0;
    end else begin
      fd_q      <= fb;
      applied_q <= fb && (bus.load || pending);
      if (fb && bus.load) begin
        shad_dig   <= bus.digits_in;
        shad_blank <= bus.blank_in;
      end else if (fb && pending) begin
        shad_dig   <= pend_dig;
        shad_blank <= pend_blank;
      end
    end
  end

  // registered pin drive from the current slot
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      seg_q <= SEG_BLANK;
      an_q  <= '1;
    end else if (cur_blank) begin
      seg_q <= SEG_BLANK;
      an_q  <= '1;
    end else begin
      seg_q <= cur_seg;
      an_q  <= ~(NUM_DIGITS'(1) << idx);
    end
  end

  assign bus.seg        = seg_q;
  assign bus.an         = an_q;
  assign bus.applied    = applied_q;
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_bcd_segment_scanner.sv
// Directed bench for the segment scanner with
// NUM_DIGITS=4 and REFRESH_DIV=4 (16-cycle frame).
module tb_bcd_segment_scanner;

  logic CLK;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  bcd_segment_scanner_if #(.NUM_DIGITS(4)) bus_if ();

  bcd_segment_scanner #(
    .NUM_DIGITS  (4),
    .REFRESH_DIV (4)
  ) dut (
    .CLK   (CLK),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_fd(output bit got);
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus_if.frame_done === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus_if.load = 1'b0;
    bus_if.digits_in = '0;
    bus_if.blank_in = '0;
    step();
    step();
    n_cmp++;
    if (bus_if.seg !== 7'h7F) begin
      n_bad++;
      $display("FAIL rst_seg got=%h exp=7f", bus_if.seg);
    end
    n_cmp++;
    if (bus_if.an !== 4'hF) begin
      n_bad++;
      $display("FAIL rst_an got=%h exp=f", bus_if.an);
    end
    n_cmp++;
    if (bus_if.applied !== 1'b0 ||
        bus_if.frame_done !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_pulses ap=%b fd=%b exp=0/0",
        bus_if.applied, bus_if.frame_done);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_idle();
    bit got;
    wait_fd(got);
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL idle_fd_timeout got=0 exp=1");
    end
    for (int f = 0; f < 3; f++) begin
      for (int i = 1; i <= 16; i++) begin
        step();
        n_cmp++;
        if (bus_if.frame_done !== (i == 16)) begin
          n_bad++;
          $display("FAIL idle_fd f=%0d i=%0d got=%b exp=%b",
            f, i, bus_if.frame_done, (i == 16));
        end
        n_cmp++;
        if (bus_if.seg !== 7'h7F || bus_if.an !== 4'hF ||
            bus_if.applied !== 1'b0) begin
          n_bad++;
          $display("FAIL idle_out seg=%h an=%h ap=%b exp=7f/f/0",
            bus_if.seg, bus_if.an, bus_if.applied);
        end
      end
    end
  endtask

  task automatic test_load_mid();
    bit got;
    logic [6:0] es [4];
    logic [3:0] ea;
    es = '{7'h19, 7'h30, 7'h24, 7'h79};
    wait_fd(got);
    repeat (5) step();
    bus_if.load = 1'b1;
    bus_if.digits_in = 16'h1234;
    bus_if.blank_in = 4'h0;
    step();
    bus_if.load = 1'b0;
    wait_fd(got);
    n_cmp++;
    if (!got || bus_if.applied !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_applied got=%b fd=%b exp=1",
        bus_if.applied, got);
    end
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 4; j++) begin
        step();
        ea = ~(4'b0001 << k);
        n_cmp++;
        if (bus_if.an !== ea || bus_if.seg !== es[k]) begin
          n_bad++;
          $display("FAIL mid_disp k=%0d an=%h seg=%h exp=%h/%h",
            k, bus_if.an, bus_if.seg, ea, es[k]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    bit got;
    int ap;
    logic [6:0] es [4];
    logic [3:0] ea;
    es = '{7'h24, 7'h79, 7'h40, 7'h10};
    ap = 0;
    wait_fd(got);
    repeat (2) step();
    bus_if.load = 1'b1;
    bus_if.digits_in = 16'h5678;
    step();
    bus_if.digits_in = 16'h9012;
    step();
    bus_if.load = 1'b0;
    wait_fd(got);
    n_cmp++;
    if (!got || bus_if.applied !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_applied got=%b exp=1",
        bus_if.applied);
    end
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 4; j++) begin
        step();
        if (bus_if.applied === 1'b1) ap++;
        ea = ~(4'b0001 << k);
        n_cmp++;
        if (bus_if.an !== ea || bus_if.seg !== es[k]) begin
          n_bad++;
          $display("FAIL b2b_disp k=%0d an=%h seg=%h exp=%h/%h",
            k, bus_if.an, bus_if.seg, ea, es[k]);
        end
      end
    end
    n_cmp++;
    if (ap != 0) begin
      n_bad++;
      $display("FAIL b2b_extra_applied got=%0d exp=0", ap);
    end
  endtask

  task automatic test_load_on_fb();
    bit got;
    logic [6:0] es [4];
    logic [3:0] ea;
    es = '{7'h3F, 7'h3F, 7'h40, 7'h40};
    wait_fd(got);
    repeat (15) step();
    bus_if.load = 1'b1;
    bus_if.digits_in = 16'h00AF;
    bus_if.blank_in = 4'h0;
    step();
    bus_if.load = 1'b0;
    n_cmp++;
    if (bus_if.frame_done !== 1'b1 ||
        bus_if.applied !== 1'b1) begin
      n_bad++;
      $display("FAIL fb_load fd=%b ap=%b exp=1/1",
        bus_if.frame_done, bus_if.applied);
    end
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 4; j++) begin
        step();
        ea = ~(4'b0001 << k);
        n_cmp++;
        if (bus_if.an !== ea || bus_if.seg !== es[k] ||
            bus_if.applied !== 1'b0) begin
          n_bad++;
          $display("FAIL fb_disp k=%0d an=%h seg=%h ap=%b exp=%h/%h/0",
            k, bus_if.an, bus_if.seg, bus_if.applied, ea, es[k]);
        end
      end
    end
    n_cmp++;
    if (bus_if.frame_done !== 1'b1) begin
      n_bad++;
      $display("FAIL fb_next_fd got=%b exp=1",
        bus_if.frame_done);
    end
  endtask

  task automatic test_blank();
    bit got;
    logic [3:0] ea;
    logic [6:0] es;
    wait_fd(got);
    repeat (3) step();
    bus_if.load = 1'b1;
    bus_if.digits_in = 16'h8888;
    bus_if.blank_in = 4'b1010;
    step();
    bus_if.load = 1'b0;
    bus_if.blank_in = 4'h0;
    wait_fd(got);
    n_cmp++;
    if (!got || bus_if.applied !== 1'b1) begin
      n_bad++;
      $display("FAIL blank_applied got=%b exp=1",
        bus_if.applied);
    end
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 4; j++) begin
        step();
        ea = (k % 2 == 1) ? 4'hF : ~(4'b0001 << k);
        es = (k % 2 == 1) ? 7'h7F : 7'h00;
        n_cmp++;
        if (bus_if.an !== ea || bus_if.seg !== es) begin
          n_bad++;
          $display("FAIL blank_disp k=%0d an=%h seg=%h exp=%h/%h",
            k, bus_if.an, bus_if.seg, ea, es);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit got;
    int ap;
    int lit;
    ap = 0;
    lit = 0;
    wait_fd(got);
    repeat (3) step();
    bus_if.load = 1'b1;
    bus_if.digits_in = 16'h1234;
    bus_if.blank_in = 4'h0;
    step();
    bus_if.load = 1'b0;
    rst_n = 1'b0;
    step();
    n_cmp++;
    if (bus_if.seg !== 7'h7F || bus_if.an !== 4'hF) begin
      n_bad++;
      $display("FAIL rmid_out seg=%h an=%h exp=7f/f",
        bus_if.seg, bus_if.an);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus_if.applied === 1'b1) ap++;
      if (bus_if.seg !== 7'h7F || bus_if.an !== 4'hF) lit++;
    end
    n_cmp++;
    if (ap != 0) begin
      n_bad++;
      $display("FAIL rmid_applied got=%0d exp=0", ap);
    end
    n_cmp++;
    if (lit != 0) begin
      n_bad++;
      $display("FAIL rmid_lit got=%0d exp=0", lit);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_idle();
    test_load_mid();
    test_back_to_back();
    test_load_on_fb();
    test_blank();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
      n_cmp, n_bad);
    $finish;
  end

endmodule
